mdu_hilo: RTL

Multiply/divide unit with the architectural HI/LO registers for the MIPS core. It takes two operands from the register-file read ports (rs/rt), runs MULT/MULTU in a fixed-latency pipeline and DIV/DIVU iteratively, and handles MTHI/MTLO writes. The HI or LO value is presented on hilo_out for MFHI/MFLO, which enters the write-back data selection alongside the ALU result. Control stalls issue while busy is high.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_divider.sv | 58 +++++
 rtl/mdu_hilo.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// controller states and the magnitude helper used for signed division.
package mdu_pkg;

   localparam logic [2:0] MD_MULT  = 3'b000;
   localparam logic [2:0] MD_MULTU = 3'b001;
   localparam logic [2:0] MD_DIV   = 3'b010;
   localparam logic [2:0] MD_DIVU  = 3'b011;
   localparam logic [2:0] MD_MTHI  = 3'b100;
   localparam logic [2:0] MD_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MUL_RUN = 2'd1,
      ST_DIV_RUN = 2'd2
   } mdu_state_e;

   // Two's-complement negate when neg is set; 0x80000000 maps to itself,
   // which is the correct unsigned magnitude.
   function automatic logic [31:0] mag32(input logic [31:0] x, input logic neg);
      return neg ? (32'd0 - x) : x;
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// Unsigned radix-2 restoring divider. quotient_o/remainder_o show the result
// of the step being taken this cycle, so the final step's result can be
// captured on the same edge that performs it.
module mdu_divider (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic        step_i,
   input  logic        finish_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] quotient_o,
   output logic [31:0] remainder_o
);

   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q;
   logic [32:0] shifted_s;
   logic [33:0] diff_s;

   // One restoring step: shift in the next dividend bit and try to subtract.
   always_comb begin
      shifted_s = {rem_q, quo_q[31]};
      diff_s    = {1'b0, shifted_s} - {2'b00, dvs_q};
      if (diff_s[33] == 1'b0) begin
         rem_d = diff_s[31:0];
         quo_d = {quo_q[30:0], 1'b1};
      end else begin
         rem_d = shifted_s[31:0];
         quo_d = {quo_q[30:0], 1'b0};
      end
   end

   assign quotient_o  = quo_d;
   assign remainder_o = rem_d;

   // Quotient accumulates in the dividend register as its bits shift out.
   always_ff @(posedge clk) begin
      if (reset || finish_i) begin
         rem_q <= 32'd0;
         quo_q <= 32'd0;
         dvs_q <= 32'd0;
      end else if (load_i) begin
         rem_q <= 32'd0;
         quo_q <= dividend_i;
         dvs_q <= divisor_i;
      end else if (step_i) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
      end else begin
         rem_q <= rem_q;
         quo_q <= quo_q;
         dvs_q <= dvs_q;
      end
   end

endmodule

// File: rtl/mdu_hilo.sv
// MIPS multiply/divide unit with architectural HI/LO registers: fixed-latency
// MULT/MULTU, 32-step iterative DIV/DIVU, and MTHI/MTLO writes.
module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        hilo_sel,
   output logic        busy,
   output logic        done,
   output logic [31:0] hilo_out
);

   mdu_state_e  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] op_a_q, op_a_d;
   logic [31:0] op_b_q, op_b_d;
   logic        sgn_q, sgn_d;
   logic        q_neg_q, q_neg_d;
   logic        r_neg_q, r_neg_d;
   logic        dz_q, dz_d;

   logic        div_load_s, div_step_s, div_finish_s;
   logic        rs_neg_s, rt_neg_s;
   logic [31:0] quotient_s, remainder_s;
   logic [63:0] ext_a_s, ext_b_s, product_s;

   assign rs_neg_s  = (md_op == MD_DIV) && rs_val[31];
   assign rt_neg_s  = (md_op == MD_DIV) && rt_val[31];
   assign ext_a_s   = {{32{sgn_q & op_a_q[31]}}, op_a_q};
   assign ext_b_s   = {{32{sgn_q & op_b_q[31]}}, op_b_q};
   assign product_s = ext_a_s * ext_b_s;

   mdu_divider u_div (
      .clk         (clk),
      .reset       (reset),
      .load_i      (div_load_s),
      .step_i      (div_step_s),
      .finish_i    (div_finish_s),
      .dividend_i  (mag32(rs_val, rs_neg_s)),
      .divisor_i   (mag32(rt_val, rt_neg_s)),
      .quotient_o  (quotient_s),
      .remainder_o (remainder_s)
   );

   // Controller next-state, operand capture and HI/LO update.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      sgn_d        = sgn_q;
      q_neg_d      = q_neg_q;
      r_neg_d      = r_neg_q;
      dz_d         = dz_q;
      div_load_s   = 1'b0;
      div_step_s   = 1'b0;
      div_finish_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (md_op)
                  MD_MULT, MD_MULTU: begin
                     op_a_d  = rs_val;
                     op_b_d  = rt_val;
                     sgn_d   = (md_op == MD_MULT);
                     cnt_d   = 5'(MULT_CYCLES - 1);
                     busy_d  = 1'b1;
                     state_d = ST_MUL_RUN;
                  end
                  MD_DIV, MD_DIVU: begin
                     q_neg_d    = rs_neg_s ^ rt_neg_s;
                     r_neg_d    = rs_neg_s;
                     div_load_s = 1'b1;
                     busy_d     = 1'b1;
                     state_d    = ST_DIV_RUN;
                     if (rt_val == 32'd0) begin
                        dz_d  = 1'b1;
                        cnt_d = 5'd0;
                     end else begin
                        dz_d  = 1'b0;
                        cnt_d = 5'(DIV_CYCLES - 1);
                     end
                  end
                  MD_MTHI: hi_d = rs_val;
                  MD_MTLO: lo_d = rs_val;
                  default: state_d = ST_IDLE;
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL_RUN: begin
            if (cnt_q == 5'd0) begin
               {hi_d, lo_d} = product_s;
               busy_d       = 1'b0;
               done_d       = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         ST_DIV_RUN: begin
            div_step_s = !dz_q;
            if (cnt_q == 5'd0) begin
               div_finish_s = 1'b1;
               if (!dz_q) begin
                  lo_d = mag32(quotient_s, q_neg_q);
                  hi_d = mag32(remainder_s, r_neg_q);
               end else begin
                  lo_d = lo_q;
                  hi_d = hi_q;
               end
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any in-flight operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 5'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         op_a_q  <= 32'd0;
         op_b_q  <= 32'd0;
         sgn_q   <= 1'b0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         sgn_q   <= sgn_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         dz_q    <= dz_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign hilo_out = hilo_sel ? hi_q : lo_q;

endmodule
